dsp_fractured_mac_shift_round_sat: RTL

Parametrised, LANES-way fractured signed multiply-accumulate.
Each lane multiplies, then loads or accumulates with add or subtract, then applies an arithmetic right shift with optional rounding and saturation.
It is the generalised successor of the two-lane fixed-width fractured accumulator, and sits in the DSP datapath between operand registers and downstream result consumers.
It adds a valid handshake, per-lane overflow flags and configurable widths.

---
 rtl/dsp_fractured_mac_shift_round_sat.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dsp_fractured_mac_shift_round_sat.sv
// LANES-way fractured signed MAC: multiply, load/accumulate (+/-), wrap or saturate, then shift and round per lane.
// Define DSP_SYMMETRIC_ROUND_EN for round-half-away-from-zero; the default build rounds half up.
module dsp_fractured_mac_shift_round_sat #(
    parameter int LANES   = 2,
    parameter int A_W     = 10,
    parameter int B_W     = 9,
    parameter int ACC_W   = 32,
    parameter int SHIFT_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   load_acc_i,
    input  logic                   subtract_i,
    input  logic [SHIFT_W-1:0]     shift_right_i,
    input  logic                   round_i,
    input  logic                   saturate_i,
    input  logic [LANES*A_W-1:0]   A,
    input  logic [LANES*B_W-1:0]   B,
    output logic [LANES*ACC_W-1:0] P,
    output logic                   out_valid,
    output logic [LANES-1:0]       overflow
);
    localparam int PROD_W = A_W + B_W;
    localparam int EXT_W  = ACC_W + 1;
    localparam int SH_W   = $clog2(ACC_W);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};

    if (ACC_W < A_W + B_W + 1) begin : g_acc_w_check
        $error("ACC_W must be at least A_W+B_W+1");
    end

    function automatic logic signed [ACC_W-1:0] sat_wrap(
        input logic signed [EXT_W-1:0] sum,
        input logic                     sat
    );
        if (sat && (sum[ACC_W] != sum[ACC_W-1]))
            return sum[ACC_W] ? ACC_MIN : ACC_MAX;
        return signed'(sum[ACC_W-1:0]);
    endfunction

    function automatic logic signed [ACC_W-1:0] shift_round(
        input logic signed [ACC_W-1:0] acc,
        input logic [SH_W-1:0]         s,
        input logic                    rnd
    );
        logic signed [ACC_W-1:0] r;
        logic [ACC_W-1:0]        mask;
        logic [ACC_W-1:0]        frac;
        logic [ACC_W-1:0]        half;
        logic                    inc;
        r    = acc >>> s;
        mask = (ACC_W'(1) << s) - ACC_W'(1);
        frac = acc & mask;
        half = ACC_W'(1) << (s - SH_W'(1));
`ifdef DSP_SYMMETRIC_ROUND_EN
        inc = acc[ACC_W-1] ? (frac > half) : (frac >= half);
`else
        inc = (frac >= half);
`endif
        // s >= 1 whenever we increment, so r is at most half range and cannot overflow
        if (rnd && (s != '0) && inc)
            r = r + ONE;
        return r;
    endfunction

    logic                        vld_p1_q, vld_p1_d;
    logic                        load_p1_q, load_p1_d;
    logic                        sub_p1_q, sub_p1_d;
    logic                        round_p1_q, round_p1_d;
    logic                        sat_p1_q, sat_p1_d;
    logic [SH_W-1:0]             shift_p1_q, shift_p1_d;
    logic [LANES-1:0][A_W-1:0]   a_p1_q, a_p1_d;
    logic [LANES-1:0][B_W-1:0]   b_p1_q, b_p1_d;

    logic                        vld_p2_q, vld_p2_d;
    logic                        round_p2_q, round_p2_d;
    logic [SH_W-1:0]             shift_p2_q, shift_p2_d;
    logic [LANES-1:0][ACC_W-1:0] acc_p2_q, acc_p2_d;
    logic [LANES-1:0]            ovf_p2_q, ovf_p2_d;

    logic                        vld_p3_q, vld_p3_d;
    logic [LANES-1:0][ACC_W-1:0] p_p3_q, p_p3_d;

    // Stage 1: capture operands and controls; shift amount clamped to ACC_W-1 here
    always_comb begin
        vld_p1_d   = in_valid;
        load_p1_d  = load_acc_i;
        sub_p1_d   = subtract_i;
        round_p1_d = round_i;
        sat_p1_d   = saturate_i;
        a_p1_d     = A;
        b_p1_d     = B;
        if (int'(shift_right_i) > ACC_W - 1)
            shift_p1_d = SH_W'(ACC_W - 1);
        else
            shift_p1_d = SH_W'(shift_right_i);
    end

    // Stage 2: multiply and update accumulators with overflow tracking
    always_comb begin : s2_comb
        logic signed [PROD_W-1:0] a_x;
        logic signed [PROD_W-1:0] b_x;
        logic signed [PROD_W-1:0] prod;
        logic signed [EXT_W-1:0]  base;
        logic signed [EXT_W-1:0]  sum;
        vld_p2_d   = vld_p1_q;
        round_p2_d = round_p2_q;
        shift_p2_d = shift_p2_q;
        acc_p2_d   = acc_p2_q;
        ovf_p2_d   = ovf_p2_q;
        a_x        = '0;
        b_x        = '0;
        prod       = '0;
        base       = '0;
        sum        = '0;
        if (vld_p1_q) begin
            round_p2_d = round_p1_q;
            shift_p2_d = shift_p1_q;
        end
        for (int l = 0; l < LANES; l++) begin
            a_x  = PROD_W'(signed'(a_p1_q[l]));
            b_x  = PROD_W'(signed'(b_p1_q[l]));
            prod = a_x * b_x;
            base = load_p1_q ? '0 : EXT_W'(signed'(acc_p2_q[l]));
            sum  = sub_p1_q ? (base - EXT_W'(prod)) : (base + EXT_W'(prod));
            if (vld_p1_q) begin
                acc_p2_d[l] = sat_wrap(sum, sat_p1_q);
                if (sum[ACC_W] != sum[ACC_W-1])
                    ovf_p2_d[l] = 1'b1;
                else if (load_p1_q)
                    ovf_p2_d[l] = 1'b0;
            end
        end
    end

    // Stage 3: shift, round and publish
    always_comb begin
        vld_p3_d = vld_p2_q;
        p_p3_d   = p_p3_q;
        if (vld_p2_q) begin
            for (int l = 0; l < LANES; l++)
                p_p3_d[l] = shift_round(signed'(acc_p2_q[l]), shift_p2_q, round_p2_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q   <= 1'b0;
            load_p1_q  <= 1'b0;
            sub_p1_q   <= 1'b0;
            round_p1_q <= 1'b0;
            sat_p1_q   <= 1'b0;
            shift_p1_q <= '0;
            a_p1_q     <= '0;
            b_p1_q     <= '0;
            vld_p2_q   <= 1'b0;
            round_p2_q <= 1'b0;
            shift_p2_q <= '0;
            acc_p2_q   <= '0;
            ovf_p2_q   <= '0;
            vld_p3_q   <= 1'b0;
            p_p3_q     <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            load_p1_q  <= load_p1_d;
            sub_p1_q   <= sub_p1_d;
            round_p1_q <= round_p1_d;
            sat_p1_q   <= sat_p1_d;
            shift_p1_q <= shift_p1_d;
            a_p1_q     <= a_p1_d;
            b_p1_q     <= b_p1_d;
            vld_p2_q   <= vld_p2_d;
            round_p2_q <= round_p2_d;
            shift_p2_q <= shift_p2_d;
            acc_p2_q   <= acc_p2_d;
            ovf_p2_q   <= ovf_p2_d;
            vld_p3_q   <= vld_p3_d;
            p_p3_q     <= p_p3_d;
        end
    end

    assign P         = p_p3_q;
    assign out_valid = vld_p3_q;
    assign overflow  = ovf_p2_q;

endmodule
